// File: rtl/a_lkp_responder.sv
`default_nettype none
// ============================================================================
// Module   : a_lkp_responder
// Purpose  : A-side lookup responder. Ages each pending request and returns
//            results by lowest table index.
// Revision : 1.0
// ============================================================================
module a_lkp_responder #(
    parameter int                     INFO_LENGTH = 32,
    parameter int                     REQ_WIDTH   = 4,
    parameter int                     DEPTH       = 8,
    parameter int                     BASE_LAT    = 2,
    parameter logic [INFO_LENGTH-1:0] RSLT_KEY    = 32'h5A5A_A5A5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         c2a_lkp_vld,
    input  logic [INFO_LENGTH-1:0]       c2a_lkp_info,
    input  logic [REQ_WIDTH-1:0]         c2a_lkp_req_id,
    output logic                         a2c_lkp_rdy,
    output logic                         a2c_lkp_rsp_vld,
    output logic [REQ_WIDTH-1:0]         a2c_lkp_rsp_id,
    output logic [INFO_LENGTH-1:0]       a2c_lkp_rslt,
    input  logic                         cfg_stall,
    output logic [$clog2(DEPTH+1)-1:0]   pend_cnt,
    output logic                         err_dup_id
);

    localparam int c_AGE_W = $clog2(BASE_LAT + 4) + 2;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_IDX_W = $clog2(DEPTH);

    logic                   r_vld  [DEPTH];
    logic [REQ_WIDTH-1:0]   r_id   [DEPTH];
    logic [INFO_LENGTH-1:0] r_rslt [DEPTH];
    logic [c_AGE_W-1:0]     r_age  [DEPTH];

    logic                   r_rsp_vld;
    logic [REQ_WIDTH-1:0]   r_rsp_id;
    logic [INFO_LENGTH-1:0] r_rsp_rslt;
    logic [c_CNT_W-1:0]     r_pend_cnt;
    logic                   r_err_dup;

    logic [DEPTH-1:0]       w_elig;
    logic [DEPTH-1:0]       w_dup_hit;
    logic [DEPTH-1:0]       w_pop_oh;
    logic [DEPTH-1:0]       w_alloc_oh;
    logic [c_IDX_W-1:0]     w_pop_idx;
    logic                   w_pop;
    logic                   w_acc;
    logic                   w_dup;
    logic [c_AGE_W-1:0]     w_new_age;
    logic [INFO_LENGTH-1:0] w_new_rslt;

    // Ready depends only on reset, stall and the registered occupancy.
    assign a2c_lkp_rdy = rst_n && !cfg_stall && (r_pend_cnt < c_CNT_W'(DEPTH));
    assign w_acc       = c2a_lkp_vld && a2c_lkp_rdy;

    assign w_new_age  = c_AGE_W'(BASE_LAT - 1) + c_AGE_W'(c2a_lkp_info[1:0]);
    assign w_new_rslt = {c2a_lkp_info[INFO_LENGTH-2:0], c2a_lkp_info[INFO_LENGTH-1]} ^ RSLT_KEY;

    // Descending scan so the lowest index is the last (winning) assignment.
    always_comb begin
        w_pop_oh   = '0;
        w_alloc_oh = '0;
        w_pop_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_pop_oh    = '0;
                w_pop_oh[i] = 1'b1;
                w_pop_idx   = c_IDX_W'(i);
            end
            if (!r_vld[i]) begin
                w_alloc_oh    = '0;
                w_alloc_oh[i] = 1'b1;
            end
        end
    end

    assign w_pop = |w_elig;
    assign w_dup = |w_dup_hit;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        assign w_elig[g]    = r_vld[g] && (r_age[g] == '0);
        assign w_dup_hit[g] = r_vld[g] && !w_pop_oh[g] && (r_id[g] == c2a_lkp_req_id);

        // The allocated slot is always invalid, so it never pops or ages here.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld[g]  <= 1'b0;
                r_id[g]   <= '0;
                r_rslt[g] <= '0;
                r_age[g]  <= '0;
            end else if (w_acc && w_alloc_oh[g]) begin
                r_vld[g]  <= 1'b1;
                r_id[g]   <= c2a_lkp_req_id;
                r_rslt[g] <= w_new_rslt;
                r_age[g]  <= w_new_age;
            end else begin
                if (w_pop_oh[g]) begin
                    r_vld[g] <= 1'b0;
                end
                if (r_vld[g] && (r_age[g] != '0)) begin
                    r_age[g] <= r_age[g] - c_AGE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_vld  <= 1'b0;
            r_rsp_id   <= '0;
            r_rsp_rslt <= '0;
            r_pend_cnt <= '0;
            r_err_dup  <= 1'b0;
        end else begin
            r_rsp_vld <= w_pop;
            if (w_pop) begin
                r_rsp_id   <= r_id[w_pop_idx];
                r_rsp_rslt <= r_rslt[w_pop_idx];
            end
            if (w_acc && !w_pop) begin
                r_pend_cnt <= r_pend_cnt + c_CNT_W'(1);
            end else if (!w_acc && w_pop) begin
                r_pend_cnt <= r_pend_cnt - c_CNT_W'(1);
            end
            if (w_acc && w_dup) begin
                r_err_dup <= 1'b1;
            end
        end
    end

    assign a2c_lkp_rsp_vld = r_rsp_vld;
    assign a2c_lkp_rsp_id  = r_rsp_id;
    assign a2c_lkp_rslt    = r_rsp_rslt;
    assign pend_cnt        = r_pend_cnt;
    assign err_dup_id      = r_err_dup;

endmodule
`default_nettype wire

// File: tb/tb_a_lkp_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_a_lkp_responder
// Purpose  : Directed and randomized checks of a_lkp_responder against a
//            slot/due-time reference model.
// Revision : 1.0
// ============================================================================
module tb_a_lkp_responder;

    localparam int DEPTH    = 8;
    localparam int BASE_LAT = 2;
    localparam logic [31:0] KEY = 32'h5A5A_A5A5;

    logic        clk;
    logic        rst_n;
    logic        c2a_lkp_vld;
    logic [31:0] c2a_lkp_info;
    logic [3:0]  c2a_lkp_req_id;
    logic        a2c_lkp_rdy;
    logic        a2c_lkp_rsp_vld;
    logic [3:0]  a2c_lkp_rsp_id;
    logic [31:0] a2c_lkp_rslt;
    logic        cfg_stall;
    logic [3:0]  pend_cnt;
    logic        err_dup_id;

    // Second instance with long latency so the table can actually fill.
    logic        f_vld;
    logic [31:0] f_info;
    logic [3:0]  f_id;
    logic        f_rdy;
    logic        f_rsp_vld;
    logic [3:0]  f_rsp_id;
    logic [31:0] f_rslt;
    logic [3:0]  f_cnt;
    logic        f_err;

    int checks = 0;
    int errors = 0;

    // Reference model: slot contents plus the absolute edge when each is due.
    logic        m_vld  [DEPTH];
    logic [3:0]  m_id   [DEPTH];
    logic [31:0] m_rslt [DEPTH];
    int          m_due  [DEPTH];
    int          m_cnt;
    int          m_edge;
    logic        m_err;
    logic        m_rsp_vld;
    logic [3:0]  m_rsp_id;
    logic [31:0] m_rsp_rslt;

    a_lkp_responder #(
        .INFO_LENGTH(32), .REQ_WIDTH(4), .DEPTH(DEPTH), .BASE_LAT(BASE_LAT), .RSLT_KEY(KEY)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .c2a_lkp_vld(c2a_lkp_vld), .c2a_lkp_info(c2a_lkp_info), .c2a_lkp_req_id(c2a_lkp_req_id),
        .a2c_lkp_rdy(a2c_lkp_rdy), .a2c_lkp_rsp_vld(a2c_lkp_rsp_vld),
        .a2c_lkp_rsp_id(a2c_lkp_rsp_id), .a2c_lkp_rslt(a2c_lkp_rslt),
        .cfg_stall(cfg_stall), .pend_cnt(pend_cnt), .err_dup_id(err_dup_id)
    );

    a_lkp_responder #(
        .INFO_LENGTH(32), .REQ_WIDTH(4), .DEPTH(DEPTH), .BASE_LAT(12), .RSLT_KEY(KEY)
    ) u_fill (
        .clk(clk), .rst_n(rst_n),
        .c2a_lkp_vld(f_vld), .c2a_lkp_info(f_info), .c2a_lkp_req_id(f_id),
        .a2c_lkp_rdy(f_rdy), .a2c_lkp_rsp_vld(f_rsp_vld),
        .a2c_lkp_rsp_id(f_rsp_id), .a2c_lkp_rslt(f_rslt),
        .cfg_stall(1'b0), .pend_cnt(f_cnt), .err_dup_id(f_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ref_rslt(input logic [31:0] info);
        return ((info << 1) | (info >> 31)) ^ KEY;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_vld[i] = 1'b0;
            m_id[i] = '0;
            m_rslt[i] = '0;
            m_due[i] = 0;
        end
        m_cnt = 0;
        m_err = 1'b0;
        m_rsp_vld = 1'b0;
        m_rsp_id = '0;
        m_rsp_rslt = '0;
    endtask

    // One clock edge: called just after a falling edge, returns at the next one.
    task automatic cycle(input logic v, input logic [31:0] inf, input logic [3:0] id, input logic st);
        int   pop;
        int   slot;
        logic dup;
        logic acc;
        logic rdy_e;
        c2a_lkp_vld    = v;
        c2a_lkp_info   = inf;
        c2a_lkp_req_id = id;
        cfg_stall      = st;
        #1;
        rdy_e = !st && (m_cnt < DEPTH);
        chk("rdy", a2c_lkp_rdy, rdy_e);
        pop = -1;
        for (int i = 0; i < DEPTH; i++)
            if (pop < 0 && m_vld[i] && m_due[i] <= m_edge) pop = i;
        acc  = v && rdy_e;
        slot = -1;
        for (int i = 0; i < DEPTH; i++)
            if (slot < 0 && !m_vld[i]) slot = i;
        dup = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (m_vld[i] && i != pop && m_id[i] == id) dup = 1'b1;
        m_rsp_vld = (pop >= 0);
        if (pop >= 0) begin
            m_rsp_id   = m_id[pop];
            m_rsp_rslt = m_rslt[pop];
            m_vld[pop] = 1'b0;
            m_cnt--;
        end
        if (acc) begin
            m_vld[slot]  = 1'b1;
            m_id[slot]   = id;
            m_rslt[slot] = ref_rslt(inf);
            m_due[slot]  = m_edge + BASE_LAT + int'(inf[1:0]);
            m_cnt++;
            if (dup) m_err = 1'b1;
        end
        @(posedge clk);
        m_edge++;
        #1;
        chk("rsp_vld", a2c_lkp_rsp_vld, m_rsp_vld);
        chk("rsp_id", a2c_lkp_rsp_id, m_rsp_id);
        chk("rslt", a2c_lkp_rslt, m_rsp_rslt);
        chk("pend_cnt", pend_cnt, m_cnt);
        chk("err_dup", err_dup_id, m_err);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 4'h0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        c2a_lkp_vld = 1'b0; c2a_lkp_info = '0; c2a_lkp_req_id = '0; cfg_stall = 1'b0;
        f_vld = 1'b0; f_info = '0; f_id = '0;
        m_edge = 0;
        model_reset();
        #1;
        chk("reset_rdy", a2c_lkp_rdy, 0);
        chk("reset_rsp_vld", a2c_lkp_rsp_vld, 0);
        chk("reset_rslt", a2c_lkp_rslt, 0);
        chk("reset_cnt", pend_cnt, 0);
        chk("reset_err", err_dup_id, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request: response appears after the third edge.
        cycle(1'b1, 32'h0000_0010, 4'd3, 1'b0);
        idle(1);
        chk("single_early", a2c_lkp_rsp_vld, 0);
        idle(1);
        chk("single_vld", a2c_lkp_rsp_vld, 1);
        chk("single_id", a2c_lkp_rsp_id, 3);
        chk("single_rslt", a2c_lkp_rslt, 32'h5A5A_A585);
        idle(1);
        chk("single_pulse", a2c_lkp_rsp_vld, 0);
        idle(4);

        // Out of order.
        cycle(1'b1, 32'h1234_5673, 4'd1, 1'b0);
        cycle(1'b1, 32'hCAFE_0000, 4'd2, 1'b0);
        idle(2);
        chk("ooo_first", {a2c_lkp_rsp_vld, a2c_lkp_rsp_id}, {1'b1, 4'd2});
        idle(2);
        chk("ooo_second", {a2c_lkp_rsp_vld, a2c_lkp_rsp_id}, {1'b1, 4'd1});
        idle(4);

        // Contention: both due after the fourth edge, lower slot wins.
        cycle(1'b1, 32'h0000_0F02, 4'd4, 1'b0);
        cycle(1'b1, 32'h0000_0A01, 4'd5, 1'b0);
        idle(3);
        chk("cont_first", {a2c_lkp_rsp_vld, a2c_lkp_rsp_id}, {1'b1, 4'd4});
        idle(1);
        chk("cont_second", {a2c_lkp_rsp_vld, a2c_lkp_rsp_id}, {1'b1, 4'd5});
        idle(4);

        // Duplicate ID.
        cycle(1'b1, 32'h0000_0001, 4'd7, 1'b0);
        chk("dup_before", err_dup_id, 0);
        cycle(1'b1, 32'h0000_0100, 4'd7, 1'b0);
        chk("dup_set", err_dup_id, 1);
        idle(6);
        chk("dup_sticky", err_dup_id, 1);

        // Stall blocks acceptance.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h0000_0000, 4'd9, 1'b1);
        chk("stall_cnt", pend_cnt, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), $urandom, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) == 0));
        end
        idle(12);

        // Fill the long-latency instance: 8 accepts, first pop at edge 15.
        f_vld = 1'b1;
        for (int j = 0; j < 8; j++) begin
            f_info = 32'h0000_0103;
            f_id = 4'(j);
            #1;
            chk("fill_rdy_open", f_rdy, 1);
            @(posedge clk);
            @(negedge clk);
        end
        f_id = 4'd9;
        #1;
        chk("fill_cnt", f_cnt, 8);
        chk("fill_rdy_full", f_rdy, 0);
        for (int j = 0; j < 7; j++) begin
            @(posedge clk);
            #1;
            chk("fill_hold_cnt", f_cnt, 8);
            @(negedge clk);
            #1;
            chk("fill_hold_rdy", f_rdy, 0);
        end
        @(posedge clk);
        #1;
        chk("fill_pop_cnt", f_cnt, 7);
        chk("fill_pop", {f_rsp_vld, f_rsp_id}, {1'b1, 4'd0});
        @(negedge clk);
        #1;
        chk("fill_rdy_back", f_rdy, 1);
        @(posedge clk);
        #1;
        chk("fill_swap_cnt", f_cnt, 7);
        chk("fill_swap_pop", {f_rsp_vld, f_rsp_id}, {1'b1, 4'd1});
        chk("fill_err", f_err, 0);
        f_vld = 1'b0;
        @(negedge clk);

        // Reset with three entries pending.
        cycle(1'b1, 32'h0000_0013, 4'd10, 1'b0);
        cycle(1'b1, 32'h0000_0023, 4'd11, 1'b0);
        cycle(1'b1, 32'h0000_0033, 4'd11, 1'b0);
        chk("pre_reset_cnt", pend_cnt, 3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_reset_rdy", a2c_lkp_rdy, 0);
        chk("mid_reset_vld", a2c_lkp_rsp_vld, 0);
        chk("mid_reset_id", a2c_lkp_rsp_id, 0);
        chk("mid_reset_rslt", a2c_lkp_rslt, 0);
        chk("mid_reset_cnt", pend_cnt, 0);
        chk("mid_reset_err", err_dup_id, 0);
        chk("mid_reset_fill_cnt", f_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
